// File: rtl/pc_branch_unit.sv
// Next-PC generator for fetch: PC register, branch/jump/JR target mux, stall-held redirect.
// Latency: a redirect reaches pc_o one edge later; a redirect seen during a stall lands on the first unstalled edge.
// Backpressure: stall freezes pc_o; a redirect arriving under stall is parked (newest wins) until stall drops.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall_i             hold the PC this cycle
//   branch_i/offset_i   taken branch, word offset relative to pcplus_i
//   jump_i/jindex_i     J/JAL redirect, index spliced into pcplus_i's upper bits
//   jr_i/jr_target_i    JR/JALR redirect to a register value
//   pcplus_i            PC+4 of the redirecting instruction
//   pc_o, pcplus4_o     registered fetch PC and its combinational successor
//   pending_o           a parked redirect is waiting for the stall to clear
//   misalign_o          a loaded target had non-zero low bits (alignment check build only)
//
// Optional feature macro: PCBU_ALIGN_CHECK_EN (force loaded targets word-aligned, flag it).

module pc_branch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               OFFW     = 16,
  parameter int               JIDXW    = 26,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [OFFW-1:0]  offset_i,
  input  logic [WIDTH-1:0] pcplus_i,
  input  logic             jump_i,
  input  logic [JIDXW-1:0] jindex_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pcplus4_o,
  output logic             pending_o,
  output logic             misalign_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic             pend_q;
  logic             pend_next;
  logic [WIDTH-1:0] ptgt_q;
  logic [WIDTH-1:0] ptgt_next;

  logic [WIDTH-1:0] off_sext;
  logic [WIDTH-1:0] off_bytes;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] target;
  logic             redirect;

  logic             load_tgt;
  logic [WIDTH-1:0] load_val;

  // Word offset -> byte offset; the add wraps naturally at WIDTH bits.
  assign off_sext   = WIDTH'($signed(offset_i));
  assign off_bytes  = off_sext << 2;
  assign branch_tgt = pcplus_i + off_bytes;
  assign jump_tgt   = {pcplus_i[WIDTH-1:JIDXW+2], jindex_i, 2'b00};

  assign redirect = jr_i | jump_i | branch_i;

  always_comb begin
    target = branch_tgt;
    if (jr_i) begin
      target = jr_target_i;
    end else if (jump_i) begin
      target = jump_tgt;
    end
  end

  // A fresh redirect always supersedes a parked one, so nothing is applied twice.
  always_comb begin
    pc_next   = pc_q;
    pend_next = pend_q;
    ptgt_next = ptgt_q;
    load_tgt  = 1'b0;
    load_val  = target;
    if (stall_i) begin
      if (redirect) begin
        pend_next = 1'b1;
        ptgt_next = target;
      end
    end else if (redirect) begin
      load_tgt  = 1'b1;
      load_val  = target;
      pend_next = 1'b0;
    end else if (pend_q) begin
      load_tgt  = 1'b1;
      load_val  = ptgt_q;
      pend_next = 1'b0;
    end else begin
      pc_next = pc_q + WIDTH'(4);
    end
    if (load_tgt) begin
`ifdef PCBU_ALIGN_CHECK_EN
      pc_next = {load_val[WIDTH-1:2], 2'b00};
`else
      pc_next = load_val;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      pend_q <= 1'b0;
      ptgt_q <= '0;
    end else begin
      pc_q   <= pc_next;
      pend_q <= pend_next;
      ptgt_q <= ptgt_next;
    end
  end

`ifdef PCBU_ALIGN_CHECK_EN
  // Flag lives for exactly the cycle the realigned target sits in pc_o.
  logic mis_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= load_tgt && (load_val[1:0] != 2'b00);
    end
  end
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o      = pc_q;
  assign pcplus4_o = pc_q + WIDTH'(4);
  assign pending_o = pend_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  localparam int          WIDTH = 32;
  localparam int          OFFW  = 16;
  localparam int          JIDXW = 26;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall_i;
  logic             branch_i;
  logic [OFFW-1:0]  offset_i;
  logic [WIDTH-1:0] pcplus_i;
  logic             jump_i;
  logic [JIDXW-1:0] jindex_i;
  logic             jr_i;
  logic [WIDTH-1:0] jr_target_i;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pcplus4_o;
  logic             pending_o;
  logic             misalign_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  pc_branch_unit #(
    .WIDTH(WIDTH), .OFFW(OFFW), .JIDXW(JIDXW), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .branch_i(branch_i),
    .offset_i(offset_i), .pcplus_i(pcplus_i), .jump_i(jump_i),
    .jindex_i(jindex_i), .jr_i(jr_i), .jr_target_i(jr_target_i),
    .pc_o(pc_o), .pcplus4_o(pcplus4_o), .pending_o(pending_o),
    .misalign_o(misalign_o)
  );

  // Monitor: every cycle's registered state is an output; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (pc_o !== e.pc) begin
        errors++;
        $display("FAIL %s pc_o: got %h want %h", n, pc_o, e.pc);
      end
      checks++;
      if (pcplus4_o !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL %s pcplus4_o: got %h want %h", n, pcplus4_o, e.pc + 32'd4);
      end
      checks++;
      if (pending_o !== e.pend) begin
        errors++;
        $display("FAIL %s pending_o: got %b want %b", n, pending_o, e.pend);
      end
      checks++;
      if (misalign_o !== e.mis) begin
        errors++;
        $display("FAIL %s misalign_o: got %b want %b", n, misalign_o, e.mis);
      end
    end
  end

  // Advance one edge with the inputs currently driven, then queue what must be seen.
  task automatic step(input string n, input logic [31:0] pc, input logic pend, input logic mis);
    exp_t e;
    @(posedge clk);
    #1;
    e.pc   = pc;
    e.pend = pend;
    e.mis  = mis;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic idle_inputs();
    stall_i     = 1'b0;
    branch_i    = 1'b0;
    offset_i    = '0;
    pcplus_i    = '0;
    jump_i      = 1'b0;
    jindex_i    = '0;
    jr_i        = 1'b0;
    jr_target_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        m;
    idle_inputs();
    reset = 1'b1;

    // Reset held two cycles
    step("reset0", RPC, 1'b0, 1'b0);
    step("reset1", RPC, 1'b0, 1'b0);
    reset = 1'b0;

    // Free run
    step("run1", 32'h0040_0004, 1'b0, 1'b0);
    step("run2", 32'h0040_0008, 1'b0, 1'b0);
    step("run3", 32'h0040_000C, 1'b0, 1'b0);

    // Branches: negative offset, positive offset, wrap at 2^32
    branch_i = 1'b1; pcplus_i = 32'h0040_0010; offset_i = 16'hFFFF;
    step("br_neg", 32'h0040_000C, 1'b0, 1'b0);
    offset_i = 16'h0003;
    step("br_pos", 32'h0040_001C, 1'b0, 1'b0);
    pcplus_i = 32'hFFFF_FFFC; offset_i = 16'h0001;
    step("br_wrap0", 32'h0000_0000, 1'b0, 1'b0);
    offset_i = 16'h0002;
    step("br_wrap4", 32'h0000_0004, 1'b0, 1'b0);
    idle_inputs();
    step("run_after_br", 32'h0000_0008, 1'b0, 1'b0);

    // Stall: jump then branch parked; the later branch wins on release
    stall_i = 1'b1; jump_i = 1'b1; jindex_i = 26'h010_0000; pcplus_i = 32'h0040_0020;
    step("stall_jump", 32'h0000_0008, 1'b1, 1'b0);
    jump_i = 1'b0; branch_i = 1'b1; offset_i = 16'h0004;
    step("stall_branch", 32'h0000_0008, 1'b1, 1'b0);
    branch_i = 1'b0;
    step("stall_idle", 32'h0000_0008, 1'b1, 1'b0);
    stall_i = 1'b0;
    step("release", 32'h0040_0030, 1'b0, 1'b0);
    step("post_release", 32'h0040_0034, 1'b0, 1'b0);

    // Unstalled jump alone
    jump_i = 1'b1; jindex_i = 26'h010_0040; pcplus_i = 32'h1000_0000;
    step("jump_direct", 32'h1040_0100, 1'b0, 1'b0);
    idle_inputs();

    // All three redirects at once: JR has priority
    jr_i = 1'b1; jump_i = 1'b1; branch_i = 1'b1;
    jr_target_i = 32'h0040_0100; jindex_i = 26'h000_0001;
    pcplus_i = 32'h0040_0010; offset_i = 16'h0008;
    step("prio_jr", 32'h0040_0100, 1'b0, 1'b0);
    idle_inputs();
    step("prio_after", 32'h0040_0104, 1'b0, 1'b0);

    // Misaligned direct JR target
    jr_i = 1'b1; jr_target_i = 32'h0040_0102;
`ifdef PCBU_ALIGN_CHECK_EN
    a = 32'h0040_0100; m = 1'b1;
`else
    a = 32'h0040_0102; m = 1'b0;
`endif
    step("mis_direct", a, 1'b0, m);
    idle_inputs();
    step("mis_clear", a + 32'd4, 1'b0, 1'b0);

    // Misaligned target through the pending path
    stall_i = 1'b1; jr_i = 1'b1; jr_target_i = 32'h0040_0203;
    step("mis_park", a + 32'd4, 1'b1, 1'b0);
    idle_inputs();
`ifdef PCBU_ALIGN_CHECK_EN
    a = 32'h0040_0200; m = 1'b1;
`else
    a = 32'h0040_0203; m = 1'b0;
`endif
    step("mis_pending", a, 1'b0, m);
    step("mis_pend_clear", a + 32'd4, 1'b0, 1'b0);

    // A new redirect on the release edge beats the parked one; parked one never reappears
    stall_i = 1'b1; jr_i = 1'b1; jr_target_i = 32'h0040_0300;
    step("old_park", a + 32'd4, 1'b1, 1'b0);
    idle_inputs();
    branch_i = 1'b1; pcplus_i = 32'h0040_0010; offset_i = 16'h0001;
    step("new_beats_old", 32'h0040_0014, 1'b0, 1'b0);
    idle_inputs();
    step("old_dropped", 32'h0040_0018, 1'b0, 1'b0);

    // Reset while a redirect is parked discards it
    stall_i = 1'b1; branch_i = 1'b1; pcplus_i = 32'h0040_0010; offset_i = 16'h0000;
    step("rst_park", 32'h0040_0018, 1'b1, 1'b0);
    branch_i = 1'b0; reset = 1'b1;
    step("rst_mid_stall", RPC, 1'b0, 1'b0);
    reset = 1'b0; stall_i = 1'b0;
    step("rst_no_pending", 32'h0040_0004, 1'b0, 1'b0);

    // Let the monitor drain the queue
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
